// File: rtl/alu_cmd_ctrl.sv
// Request/response front end for a combinational ALU: issues registered operands, waits the settle time, returns R/Z.
// Latency: response valid 1+N cycles after accept (N = MUL_SETTLE for MUL, else SETTLE); illegal opcodes answer after 1 cycle.
// Backpressure: one op in flight; req_ready low until the response handshakes. Define ALU_CMD_STATS_EN for stat_ops/stat_err counters.
module alu_cmd_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SETTLE     = 1,
    parameter int MUL_SETTLE = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_z,
`ifdef ALU_CMD_STATS_EN
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_err,
`endif
    output logic             rsp_err
);

    localparam int SET_N = (SETTLE < 1) ? 1 : SETTLE;
    localparam int MUL_N = (MUL_SETTLE < 1) ? 1 : MUL_SETTLE;
    localparam int MAX_N = (SET_N > MUL_N) ? SET_N : MUL_N;
    localparam int CW    = (MAX_N < 2) ? 1 : $clog2(MAX_N + 1);

    localparam logic [2:0] OP_MUL = 3'b100;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
        $error("alu_cmd_ctrl: WIDTH and CNT_W must be positive");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             req_ready_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_r_q;
    logic             rsp_z_q;
    logic             rsp_err_q;

    logic             op_legal;
    logic [CW-1:0]    cnt_d;

    assign op_legal = (req_op != 3'b000) && (req_op != 3'b111);
    assign cnt_d    = (req_op == OP_MUL) ? MUL_N[CW-1:0] : SET_N[CW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_z_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (op_legal) begin
                            alu_op_q <= req_op;
                            alu_a_q  <= req_a;
                            alu_b_q  <= req_b;
                            cnt_q    <= cnt_d;
                            state_q  <= EXEC;
                        end else begin
                            // Illegal opcodes never reach the ALU; answer with a zero result.
                            rsp_r_q     <= '0;
                            rsp_z_q     <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        rsp_r_q     <= alu_r;
                        rsp_z_q     <= alu_z;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_CMD_STATS_EN
    logic [CNT_W-1:0] stat_ops_q;
    logic [CNT_W-1:0] stat_err_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else if (rsp_valid_q && rsp_ready) begin
            if (stat_ops_q != '1) begin
                stat_ops_q <= stat_ops_q + CNT_W'(1);
            end
            if (rsp_err_q && (stat_err_q != '1)) begin
                stat_err_q <= stat_err_q + CNT_W'(1);
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_err = stat_err_q;
`endif

    assign req_ready = req_ready_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;

endmodule
